// File: rtl/input_p4_dispatcher_pkg.sv
// Shared types and header-field offsets for the ingress dispatcher.
// Offsets are bit positions within tdata, with byte 0 = tdata[7:0].
package input_p4_dispatcher_pkg;

    typedef enum logic [0:0] {
        StIdle,
        StFwd
    } state_e;

    localparam logic [15:0] ETH_VLAN = 16'h8100;

    localparam int unsigned EthTypeHiLsb = 96;   // byte 12
    localparam int unsigned EthTypeLoLsb = 104;  // byte 13
    localparam int unsigned VidHiLsb     = 112;  // low nibble of byte 14
    localparam int unsigned VidLoLsb     = 120;  // byte 15
    localparam int unsigned HdrBytes     = 16;   // bytes that must be valid to trust the tag

    function automatic logic [2:0] route_idx(input logic [15:0] eth_type,
                                             input logic [11:0] vid,
                                             input logic        hdr_valid,
                                             input int unsigned num_vs,
                                             input int unsigned dflt);
        if (eth_type == ETH_VLAN && hdr_valid && 32'(vid) < num_vs) begin
            return vid[2:0];
        end
        return 3'(dflt);
    endfunction

endpackage

// File: rtl/fallthrough_small_fifo.sv
// First-word-fallthrough FIFO: the head entry is visible on dout_o whenever empty_o is low.
// nearly_full_o asserts at ProgFullThreshold entries so a producer can stop before overflow.
module fallthrough_small_fifo #(
    parameter int unsigned Width             = 72,
    parameter int unsigned MaxDepthBits      = 3,
    parameter int unsigned ProgFullThreshold = (2 ** MaxDepthBits) - 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [Width-1:0] din_i,
    input  logic             wr_en_i,
    input  logic             rd_en_i,
    output logic [Width-1:0] dout_o,
    output logic             nearly_full_o,
    output logic             empty_o
);

    localparam int unsigned Depth = 2 ** MaxDepthBits;

    logic [Width-1:0]        mem_q [Depth];
    logic [MaxDepthBits-1:0] wr_ptr_q, wr_ptr_d;
    logic [MaxDepthBits-1:0] rd_ptr_q, rd_ptr_d;
    logic [MaxDepthBits:0]   count_q, count_d;
    logic                    full;
    logic                    do_wr;
    logic                    do_rd;

    assign full          = (32'(count_q) == Depth);
    assign empty_o       = (count_q == '0);
    assign nearly_full_o = (32'(count_q) >= ProgFullThreshold);
    assign dout_o        = mem_q[rd_ptr_q];

    always_comb begin
        do_rd    = rd_en_i && !empty_o;
        // A pop frees the slot in the same cycle, so push-when-full is allowed alongside it.
        do_wr    = wr_en_i && (!full || do_rd);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_wr) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_rd) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (do_wr && !do_rd) begin
            count_d = count_q + 1'b1;
        end else if (!do_wr && do_rd) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_wr) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

endmodule

// File: rtl/input_p4_dispatcher.sv
// Steers whole AXI4-Stream packets to one of five virtual P4 switches by 802.1Q VLAN ID,
// counting dispatched packets per switch.
module input_p4_dispatcher
    import input_p4_dispatcher_pkg::*;
#(
    parameter int unsigned C_M_AXIS_DATA_WIDTH  = 256,
    parameter int unsigned C_S_AXIS_DATA_WIDTH  = 256,
    parameter int unsigned C_M_AXIS_TUSER_WIDTH = 304,
    parameter int unsigned C_S_AXIS_TUSER_WIDTH = 304,
    parameter int unsigned NUM_VSWITCH          = 5,
    parameter int unsigned DEFAULT_VSWITCH      = 0,
    parameter int unsigned CNT_WIDTH            = 32
) (
    input  logic                                 axis_aclk,
    input  logic                                 axis_resetn,

    input  logic [C_S_AXIS_DATA_WIDTH-1:0]       s_axis_tdata,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]     s_axis_tkeep,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]      s_axis_tuser,
    input  logic                                 s_axis_tvalid,
    input  logic                                 s_axis_tlast,
    output logic                                 s_axis_tready,

    output logic [C_M_AXIS_DATA_WIDTH-1:0]       m_axis_0_tdata,
    output logic [C_M_AXIS_DATA_WIDTH/8-1:0]     m_axis_0_tkeep,
    output logic [C_M_AXIS_TUSER_WIDTH-1:0]      m_axis_0_tuser,
    output logic                                 m_axis_0_tvalid,
    output logic                                 m_axis_0_tlast,
    input  logic                                 m_axis_0_tready,

    output logic [C_M_AXIS_DATA_WIDTH-1:0]       m_axis_1_tdata,
    output logic [C_M_AXIS_DATA_WIDTH/8-1:0]     m_axis_1_tkeep,
    output logic [C_M_AXIS_TUSER_WIDTH-1:0]      m_axis_1_tuser,
    output logic                                 m_axis_1_tvalid,
    output logic                                 m_axis_1_tlast,
    input  logic                                 m_axis_1_tready,

    output logic [C_M_AXIS_DATA_WIDTH-1:0]       m_axis_2_tdata,
    output logic [C_M_AXIS_DATA_WIDTH/8-1:0]     m_axis_2_tkeep,
    output logic [C_M_AXIS_TUSER_WIDTH-1:0]      m_axis_2_tuser,
    output logic                                 m_axis_2_tvalid,
    output logic                                 m_axis_2_tlast,
    input  logic                                 m_axis_2_tready,

    output logic [C_M_AXIS_DATA_WIDTH-1:0]       m_axis_3_tdata,
    output logic [C_M_AXIS_DATA_WIDTH/8-1:0]     m_axis_3_tkeep,
    output logic [C_M_AXIS_TUSER_WIDTH-1:0]      m_axis_3_tuser,
    output logic                                 m_axis_3_tvalid,
    output logic                                 m_axis_3_tlast,
    input  logic                                 m_axis_3_tready,

    output logic [C_M_AXIS_DATA_WIDTH-1:0]       m_axis_4_tdata,
    output logic [C_M_AXIS_DATA_WIDTH/8-1:0]     m_axis_4_tkeep,
    output logic [C_M_AXIS_TUSER_WIDTH-1:0]      m_axis_4_tuser,
    output logic                                 m_axis_4_tvalid,
    output logic                                 m_axis_4_tlast,
    input  logic                                 m_axis_4_tready,

    output logic [NUM_VSWITCH*CNT_WIDTH-1:0]     vs_pkt_cnt,
    output logic                                 pkt_in
);

    localparam int unsigned DataW = C_S_AXIS_DATA_WIDTH;
    localparam int unsigned UserW = C_S_AXIS_TUSER_WIDTH;
    localparam int unsigned KeepW = C_S_AXIS_DATA_WIDTH / 8;
    localparam int unsigned FifoW = DataW + UserW + KeepW + 1;

    logic [FifoW-1:0] fifo_din;
    logic [FifoW-1:0] fifo_dout;
    logic             fifo_nearly_full;
    logic             fifo_empty;
    logic             fifo_rd;

    logic [DataW-1:0] head_data;
    logic [UserW-1:0] head_user;
    logic [KeepW-1:0] head_keep;
    logic             head_last;
    logic [15:0]      head_eth_type;
    logic [11:0]      head_vid;
    logic [2:0]       head_idx;

    state_e                                 state_q, state_d;
    logic [2:0]                             sel_q, sel_d;
    logic                                   pkt_in_q, pkt_in_d;
    logic [NUM_VSWITCH-1:0][CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic [NUM_VSWITCH-1:0]                 m_tvalid;
    logic [NUM_VSWITCH-1:0]                 m_tready;

    assign fifo_din      = {s_axis_tlast, s_axis_tkeep, s_axis_tuser, s_axis_tdata};
    assign s_axis_tready = !fifo_nearly_full;

    fallthrough_small_fifo #(
        .Width        (FifoW),
        .MaxDepthBits (6)
    ) u_in_fifo (
        .clk_i         (axis_aclk),
        .rst_ni        (axis_resetn),
        .din_i         (fifo_din),
        .wr_en_i       (s_axis_tvalid && !fifo_nearly_full),
        .rd_en_i       (fifo_rd),
        .dout_o        (fifo_dout),
        .nearly_full_o (fifo_nearly_full),
        .empty_o       (fifo_empty)
    );

    assign head_data = fifo_dout[DataW-1:0];
    assign head_user = fifo_dout[DataW +: UserW];
    assign head_keep = fifo_dout[DataW+UserW +: KeepW];
    assign head_last = fifo_dout[FifoW-1];

    // Only meaningful while idle, when the FIFO head is the first beat of a packet.
    assign head_eth_type = {head_data[EthTypeHiLsb +: 8], head_data[EthTypeLoLsb +: 8]};
    assign head_vid      = {head_data[VidHiLsb +: 4], head_data[VidLoLsb +: 8]};
    assign head_idx      = route_idx(head_eth_type, head_vid, &head_keep[HdrBytes-1:0],
                                     NUM_VSWITCH, DEFAULT_VSWITCH);

    assign m_tready = {m_axis_4_tready, m_axis_3_tready, m_axis_2_tready,
                       m_axis_1_tready, m_axis_0_tready};

    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        pkt_in_d = 1'b0;
        cnt_d    = cnt_q;
        m_tvalid = '0;
        fifo_rd  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!fifo_empty) begin
                    m_tvalid[head_idx] = 1'b1;
                    if (m_tready[head_idx]) begin
                        fifo_rd         = 1'b1;
                        sel_d           = head_idx;
                        pkt_in_d        = 1'b1;
                        cnt_d[head_idx] = cnt_q[head_idx] + CNT_WIDTH'(1);
                        state_d         = head_last ? StIdle : StFwd;
                    end
                end
            end
            StFwd: begin
                if (!fifo_empty) begin
                    m_tvalid[sel_q] = 1'b1;
                    if (m_tready[sel_q]) begin
                        fifo_rd = 1'b1;
                        if (head_last) begin
                            state_d = StIdle;
                        end
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge axis_aclk or negedge axis_resetn) begin
        if (!axis_resetn) begin
            state_q  <= StIdle;
            sel_q    <= '0;
            pkt_in_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            pkt_in_q <= pkt_in_d;
            cnt_q    <= cnt_d;
        end
    end

    assign pkt_in     = pkt_in_q;
    assign vs_pkt_cnt = cnt_q;

    // Payload is broadcast; only tvalid distinguishes the destination.
    assign m_axis_0_tdata = head_data;
    assign m_axis_1_tdata = head_data;
    assign m_axis_2_tdata = head_data;
    assign m_axis_3_tdata = head_data;
    assign m_axis_4_tdata = head_data;

    assign m_axis_0_tkeep = head_keep;
    assign m_axis_1_tkeep = head_keep;
    assign m_axis_2_tkeep = head_keep;
    assign m_axis_3_tkeep = head_keep;
    assign m_axis_4_tkeep = head_keep;

    assign m_axis_0_tuser = head_user;
    assign m_axis_1_tuser = head_user;
    assign m_axis_2_tuser = head_user;
    assign m_axis_3_tuser = head_user;
    assign m_axis_4_tuser = head_user;

    assign m_axis_0_tlast = head_last;
    assign m_axis_1_tlast = head_last;
    assign m_axis_2_tlast = head_last;
    assign m_axis_3_tlast = head_last;
    assign m_axis_4_tlast = head_last;

    assign m_axis_0_tvalid = m_tvalid[0];
    assign m_axis_1_tvalid = m_tvalid[1];
    assign m_axis_2_tvalid = m_tvalid[2];
    assign m_axis_3_tvalid = m_tvalid[3];
    assign m_axis_4_tvalid = m_tvalid[4];

endmodule

// File: tb/tb_input_p4_dispatcher.sv
// Directed bench for input_p4_dispatcher: a routing vector table plus hand-written
// sequences for multi-beat delivery, back-to-back packets, stalls, reset and counter wrap.
module tb_input_p4_dispatcher;

    localparam int DW = 256;
    localparam int UW = 304;
    localparam int KW = 32;
    localparam int CW = 32;
    localparam int NV = 5;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    logic [DW-1:0]    s_tdata = '0;
    logic [KW-1:0]    s_tkeep = '0;
    logic [UW-1:0]    s_tuser = '0;
    logic             s_tvalid = 1'b0;
    logic             s_tlast = 1'b0;
    logic             s_tready;

    logic [DW-1:0]    m_tdata  [NV];
    logic [KW-1:0]    m_tkeep  [NV];
    logic [UW-1:0]    m_tuser  [NV];
    logic             m_tvalid [NV];
    logic             m_tlast  [NV];
    logic             m_tready [NV];

    logic [NV*CW-1:0] vs_pkt_cnt;
    logic             pkt_in;

    input_p4_dispatcher dut (
        .axis_aclk       (clk),
        .axis_resetn     (rstn),
        .s_axis_tdata    (s_tdata),
        .s_axis_tkeep    (s_tkeep),
        .s_axis_tuser    (s_tuser),
        .s_axis_tvalid   (s_tvalid),
        .s_axis_tlast    (s_tlast),
        .s_axis_tready   (s_tready),
        .m_axis_0_tdata  (m_tdata[0]),  .m_axis_0_tkeep (m_tkeep[0]),
        .m_axis_0_tuser  (m_tuser[0]),  .m_axis_0_tvalid(m_tvalid[0]),
        .m_axis_0_tlast  (m_tlast[0]),  .m_axis_0_tready(m_tready[0]),
        .m_axis_1_tdata  (m_tdata[1]),  .m_axis_1_tkeep (m_tkeep[1]),
        .m_axis_1_tuser  (m_tuser[1]),  .m_axis_1_tvalid(m_tvalid[1]),
        .m_axis_1_tlast  (m_tlast[1]),  .m_axis_1_tready(m_tready[1]),
        .m_axis_2_tdata  (m_tdata[2]),  .m_axis_2_tkeep (m_tkeep[2]),
        .m_axis_2_tuser  (m_tuser[2]),  .m_axis_2_tvalid(m_tvalid[2]),
        .m_axis_2_tlast  (m_tlast[2]),  .m_axis_2_tready(m_tready[2]),
        .m_axis_3_tdata  (m_tdata[3]),  .m_axis_3_tkeep (m_tkeep[3]),
        .m_axis_3_tuser  (m_tuser[3]),  .m_axis_3_tvalid(m_tvalid[3]),
        .m_axis_3_tlast  (m_tlast[3]),  .m_axis_3_tready(m_tready[3]),
        .m_axis_4_tdata  (m_tdata[4]),  .m_axis_4_tkeep (m_tkeep[4]),
        .m_axis_4_tuser  (m_tuser[4]),  .m_axis_4_tvalid(m_tvalid[4]),
        .m_axis_4_tlast  (m_tlast[4]),  .m_axis_4_tready(m_tready[4]),
        .vs_pkt_cnt      (vs_pkt_cnt),
        .pkt_in          (pkt_in)
    );

    typedef struct {
        int          port;
        logic [31:0] tag;
        logic        last;
        int          cyc;
    } beat_t;

    typedef struct {
        logic [15:0] et;
        logic [11:0] vid;
        logic [31:0] keep;
        int          exp_port;
    } vec_t;

    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    beat_t       log_q[$];
    int          valid_cycles [NV];
    int          pulses = 0;
    int          stable_err = 0;
    int          multi_err = 0;
    int          user_err = 0;
    logic        hold [NV];
    logic [DW-1:0] hold_data [NV];
    logic [31:0] exp_cnt [NV];

    always @(posedge clk) cyc <= cyc + 1;

    // Passive monitor; everything here is sampled mid-cycle, so it is what the next edge accepts.
    always @(negedge clk) begin
        int nvalid;
        nvalid = 0;
        if (pkt_in) pulses++;
        for (int p = 0; p < NV; p++) begin
            if (!rstn) begin
                hold[p] = 1'b0;
            end else begin
                if (hold[p] && (!m_tvalid[p] || m_tdata[p] !== hold_data[p])) stable_err++;
                if (m_tvalid[p]) begin
                    nvalid++;
                    valid_cycles[p]++;
                    if (m_tuser[p][31:0] !== ~m_tdata[p][31:0]) user_err++;
                end
                if (m_tvalid[p] && m_tready[p]) begin
                    log_q.push_back('{port: p, tag: m_tdata[p][31:0], last: m_tlast[p], cyc: cyc});
                end
                hold[p]      = m_tvalid[p] && !m_tready[p];
                hold_data[p] = m_tdata[p];
            end
        end
        if (nvalid > 1) multi_err++;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_stats();
        log_q.delete();
        pulses = 0;
        for (int p = 0; p < NV; p++) valid_cycles[p] = 0;
    endtask

    function automatic logic [DW-1:0] make_data(input logic [15:0] et, input logic [11:0] vid,
                                                input logic [31:0] tag);
        logic [DW-1:0] d;
        d = '0;
        d[31:0]    = tag;
        d[103:96]  = et[15:8];
        d[111:104] = et[7:0];
        d[115:112] = vid[11:8];
        d[127:120] = vid[7:0];
        return d;
    endfunction

    // Starts driving immediately; call just after a rising edge. Returns just after one.
    task automatic send_pkt(input logic [15:0] et, input logic [11:0] vid,
                            input logic [31:0] keep, input int nbeats, input logic [15:0] id);
        for (int b = 0; b < nbeats; b++) begin
            int waited;
            waited   = 0;
            s_tdata  = make_data(et, vid, {id, 16'(b)});
            s_tuser  = '0;
            s_tuser[31:0] = ~{id, 16'(b)};
            s_tuser[UW-1 -: 8] = 8'hA5;
            s_tkeep  = keep;
            s_tlast  = (b == nbeats - 1);
            s_tvalid = 1'b1;
            @(negedge clk);
            while (!s_tready && waited < 500) begin
                @(negedge clk);
                waited++;
            end
            if (!s_tready) begin
                checks++;
                failures++;
                $display("FAIL send_timeout: s_axis_tready stuck low, got 0 expected 1");
                s_tvalid = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    function automatic logic [31:0] cnt_of(input int p);
        return vs_pkt_cnt[p*CW +: CW];
    endfunction

    vec_t vecs [10];

    initial begin : main
        int any_valid;
        int start_cyc;
        int order_err;
        int got;
        logic dropped;
        logic [NV-1:0][CW-1:0] preload;

        vecs[0] = '{16'h8100, 12'd3,   32'hFFFF_FFFF, 3};
        vecs[1] = '{16'h0800, 12'd3,   32'hFFFF_FFFF, 0};
        vecs[2] = '{16'h8100, 12'd7,   32'hFFFF_FFFF, 0};
        vecs[3] = '{16'h8100, 12'd1,   32'hFFFF_FFFF, 1};
        vecs[4] = '{16'h8100, 12'd4,   32'hFFFF_FFFF, 4};
        vecs[5] = '{16'h8100, 12'd5,   32'hFFFF_FFFF, 0};
        vecs[6] = '{16'h8100, 12'd2,   32'h0000_7FFF, 0};
        vecs[7] = '{16'h8100, 12'h103, 32'hFFFF_FFFF, 0};
        vecs[8] = '{16'h8100, 12'd2,   32'h0000_FFFF, 2};
        vecs[9] = '{16'h8101, 12'd2,   32'hFFFF_FFFF, 0};

        for (int p = 0; p < NV; p++) begin
            m_tready[p] = 1'b1;
            exp_cnt[p]  = '0;
            hold[p]     = 1'b0;
        end
        clear_stats();

        wait_cyc(3);
        rstn = 1'b1;
        wait_cyc(1);
        any_valid = 0;
        for (int p = 0; p < NV; p++) if (m_tvalid[p]) any_valid++;
        check("reset_tvalid", 64'(any_valid), 64'd0);
        check("reset_tready", 64'(s_tready), 64'd1);
        check("reset_cnt", 64'(vs_pkt_cnt != '0), 64'd0);
        check("reset_pkt_in", 64'(pkt_in), 64'd0);

        // Routing table, one single-beat packet per entry.
        for (int i = 0; i < 10; i++) begin
            clear_stats();
            send_pkt(vecs[i].et, vecs[i].vid, vecs[i].keep, 1, 16'(i));
            wait_cyc(3);
            exp_cnt[vecs[i].exp_port]++;
            check($sformatf("vec%0d_beats", i), 64'(log_q.size()), 64'd1);
            if (log_q.size() > 0) check($sformatf("vec%0d_port", i), 64'(log_q[0].port),
                                        64'(vecs[i].exp_port));
            check($sformatf("vec%0d_cnt", i), 64'(cnt_of(vecs[i].exp_port)),
                  64'(exp_cnt[vecs[i].exp_port]));
        end

        // Three-beat tagged packet to switch 3.
        clear_stats();
        start_cyc = cyc;
        send_pkt(16'h8100, 12'd3, 32'hFFFF_FFFF, 3, 16'h0100);
        wait_cyc(4);
        exp_cnt[3]++;
        check("p3_beats", 64'(log_q.size()), 64'd3);
        if (log_q.size() == 3) begin
            check("p3_latency", 64'(log_q[0].cyc - start_cyc), 64'd1);
            check("p3_consecutive", 64'(log_q[2].cyc - log_q[0].cyc), 64'd2);
            check("p3_lasts", 64'({log_q[0].last, log_q[1].last, log_q[2].last}), 64'b001);
            check("p3_port", 64'(log_q[1].port), 64'd3);
        end
        check("p3_valid_cycles", 64'(valid_cycles[3]), 64'd3);
        check("p3_other_valid", 64'(valid_cycles[0] + valid_cycles[1] + valid_cycles[2] +
                                    valid_cycles[4]), 64'd0);
        check("p3_pkt_in", 64'(pulses), 64'd1);
        check("p3_cnt", 64'(cnt_of(3)), 64'(exp_cnt[3]));

        // Back-to-back single-beat packets must not leave a bubble.
        clear_stats();
        send_pkt(16'h8100, 12'd1, 32'hFFFF_FFFF, 1, 16'h0200);
        send_pkt(16'h8100, 12'd2, 32'hFFFF_FFFF, 1, 16'h0201);
        send_pkt(16'h8100, 12'd4, 32'hFFFF_FFFF, 1, 16'h0202);
        wait_cyc(4);
        exp_cnt[1]++;
        exp_cnt[2]++;
        exp_cnt[4]++;
        check("b2b_beats", 64'(log_q.size()), 64'd3);
        if (log_q.size() == 3) begin
            check("b2b_ports", 64'({4'(log_q[0].port), 4'(log_q[1].port), 4'(log_q[2].port)}),
                  64'h124);
            check("b2b_gap01", 64'(log_q[1].cyc - log_q[0].cyc), 64'd1);
            check("b2b_gap12", 64'(log_q[2].cyc - log_q[1].cyc), 64'd1);
        end
        check("b2b_pkt_in", 64'(pulses), 64'd3);

        // Long packet to switch 2 with a stall long enough to fill the FIFO.
        clear_stats();
        dropped = 1'b0;
        fork
            send_pkt(16'h8100, 12'd2, 32'hFFFF_FFFF, 80, 16'h0300);
            begin
                for (int w = 0; w < 200 && log_q.size() < 3; w++) wait_cyc(1);
                m_tready[2] = 1'b0;
                for (int w = 0; w < 300 && s_tready; w++) wait_cyc(1);
                dropped = !s_tready;
                wait_cyc(10);
                m_tready[2] = 1'b1;
            end
        join
        wait_cyc(100);
        exp_cnt[2]++;
        check("stall_tready_dropped", 64'(dropped), 64'd1);
        check("stall_beats", 64'(log_q.size()), 64'd80);
        order_err = 0;
        foreach (log_q[i]) begin
            if (log_q[i].port != 2 || log_q[i].tag != {16'h0300, 16'(i)} ||
                log_q[i].last != (i == 79)) order_err++;
        end
        check("stall_order", 64'(order_err), 64'd0);
        check("stall_cnt", 64'(cnt_of(2)), 64'(exp_cnt[2]));
        check("stall_tready_back", 64'(s_tready), 64'd1);

        // Reset during beat 2 of a 4-beat packet.
        clear_stats();
        s_tdata  = make_data(16'h8100, 12'd1, 32'h0400_0000);
        s_tuser  = '0;
        s_tuser[31:0] = ~32'h0400_0000;
        s_tkeep  = 32'hFFFF_FFFF;
        s_tlast  = 1'b0;
        s_tvalid = 1'b1;
        wait_cyc(1);
        s_tdata  = make_data(16'h8100, 12'd1, 32'h0400_0001);
        s_tuser[31:0] = ~32'h0400_0001;
        wait_cyc(1);
        s_tdata  = make_data(16'h8100, 12'd1, 32'h0400_0002);
        s_tuser[31:0] = ~32'h0400_0002;
        exp_cnt[1]++;
        check("rst_pre_cnt", 64'(cnt_of(1)), 64'(exp_cnt[1]));
        #2;
        rstn = 1'b0;
        #1;
        any_valid = 0;
        for (int p = 0; p < NV; p++) if (m_tvalid[p]) any_valid++;
        check("rst_tvalid", 64'(any_valid), 64'd0);
        check("rst_cnt", 64'(vs_pkt_cnt != '0), 64'd0);
        s_tvalid = 1'b0;
        wait_cyc(2);
        rstn = 1'b1;
        for (int p = 0; p < NV; p++) exp_cnt[p] = '0;
        wait_cyc(1);
        clear_stats();
        send_pkt(16'h8100, 12'd4, 32'hFFFF_FFFF, 1, 16'h0500);
        wait_cyc(3);
        exp_cnt[4]++;
        check("post_rst_beats", 64'(log_q.size()), 64'd1);
        if (log_q.size() > 0) check("post_rst_port", 64'(log_q[0].port), 64'd4);
        check("post_rst_cnt", 64'(cnt_of(4)), 64'(exp_cnt[4]));

        // Counter wrap: preload switch 4 with all ones and dispatch two packets.
        for (int p = 0; p < NV; p++) preload[p] = exp_cnt[p];
        preload[4] = 32'hFFFF_FFFF;
        force dut.cnt_q = preload;
        #1;
        release dut.cnt_q;
        #1;
        check("wrap_preload", 64'(cnt_of(4)), 64'hFFFF_FFFF);
        wait_cyc(1);
        send_pkt(16'h8100, 12'd4, 32'hFFFF_FFFF, 1, 16'h0600);
        send_pkt(16'h8100, 12'd4, 32'hFFFF_FFFF, 1, 16'h0601);
        wait_cyc(3);
        check("wrap_cnt", 64'(cnt_of(4)), 64'd1);
        got = 0;
        for (int p = 0; p < 4; p++) if (cnt_of(p) != exp_cnt[p]) got++;
        check("wrap_others", 64'(got), 64'd0);

        check("data_stable", 64'(stable_err), 64'd0);
        check("single_valid", 64'(multi_err), 64'd0);
        check("tuser_passthrough", 64'(user_err), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
